// File: rtl/ntt_coef_packer.sv
// Packs a stream of 12-bit coefficients, reduced mod Q, into 16-lane words.
// Drives the NTT core start/valid_input/din handshake for one polynomial per run.
module ntt_coef_packer #(
  parameter int DATA_WIDTH  = 12,
  parameter int LANES       = 16,
  parameter int INPUT_WIDTH = 192,
  parameter int N_WORDS     = 16,
  parameter int Q           = 3329
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   go_i,
  input  logic                   mode_i,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   done_all,
  output logic                   start,
  output logic                   is_NTT,
  output logic                   valid_input,
  output logic [INPUT_WIDTH-1:0] din,
  output logic                   busy,
  output logic                   done_o,
  output logic                   err_range,
  output logic                   err_short
);

  localparam int LW = $clog2(LANES);
  localparam int WW = $clog2(N_WORDS);
  localparam logic [LW-1:0] LANE_END = LW'(LANES - 1);
  localparam logic [WW-1:0] WORD_END = WW'(N_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] QV = DATA_WIDTH'(Q);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD, S_PAD, S_WAIT, S_DONE
  } state_t;

  state_t                 state;
  logic [LW-1:0]          lane_cnt;
  logic [WW-1:0]          word_cnt;
  logic [INPUT_WIDTH-1:0] asm_q;

  logic                   xfer;
  logic                   over;
  logic [DATA_WIDTH-1:0]  red;
  logic [INPUT_WIDTH-1:0] word_nxt;
  logic                   lane_end;
  logic                   word_end;

  assign s_ready  = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign xfer     = s_valid && s_ready;
  assign lane_end = (lane_cnt == LANE_END);
  assign word_end = (word_cnt == WORD_END);

  // Single conditional subtraction and lane insert into the assembly word.
  always_comb begin
    over     = (s_data >= QV);
    red      = over ? s_data - QV : s_data;
    word_nxt = asm_q;
    word_nxt[lane_cnt*DATA_WIDTH +: DATA_WIDTH] = red;
  end

  // Run sequencer: load, optional zero padding, wait for core, completion.
  // Assembly register is cleared per word so unfilled lanes read as zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      lane_cnt    <= '0;
      word_cnt    <= '0;
      asm_q       <= '0;
      din         <= '0;
      start       <= 1'b0;
      valid_input <= 1'b0;
      done_o      <= 1'b0;
      err_range   <= 1'b0;
      err_short   <= 1'b0;
      is_NTT      <= 1'b0;
    end else begin
      start       <= 1'b0;
      valid_input <= 1'b0;
      done_o      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go_i) begin
            state     <= S_START;
            start     <= 1'b1;
            is_NTT    <= mode_i;
            err_range <= 1'b0;
            err_short <= 1'b0;
            lane_cnt  <= '0;
            word_cnt  <= '0;
            asm_q     <= '0;
          end
        end
        S_START: state <= S_LOAD;
        S_LOAD: begin
          if (xfer) begin
            if (over) err_range <= 1'b1;
            if (lane_end || s_last) begin
              din         <= word_nxt;
              valid_input <= 1'b1;
              asm_q       <= '0;
              lane_cnt    <= '0;
              word_cnt    <= word_cnt + 1'b1;
              if (s_last && !(lane_end && word_end))
                err_short <= 1'b1;
              if (word_end)
                state <= S_WAIT;
              else if (s_last)
                state <= S_PAD;
            end else begin
              asm_q    <= word_nxt;
              lane_cnt <= lane_cnt + 1'b1;
            end
          end
        end
        S_PAD: begin
          din         <= '0;
          valid_input <= 1'b1;
          word_cnt    <= word_cnt + 1'b1;
          if (word_end) state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_all) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_coef_packer.sv
// Scoreboard bench for ntt_coef_packer.
// Expected words come from a list-level model of the coefficient stream.
module tb_ntt_coef_packer;

  localparam int QM = 3329;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         go_i, mode_i;
  logic         s_valid, s_last, s_ready;
  logic [11:0]  s_data;
  logic         done_all;
  logic         start, is_NTT, valid_input;
  logic [191:0] din;
  logic         busy, done_o, err_range, err_short;

  int n_checks = 0;
  int n_fail   = 0;
  int coef[256];
  logic [191:0] sb[$];

  ntt_coef_packer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .go_i(go_i), .mode_i(mode_i),
    .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready),
    .done_all(done_all), .start(start),
    .is_NTT(is_NTT), .valid_input(valid_input),
    .din(din), .busy(busy), .done_o(done_o),
    .err_range(err_range), .err_short(err_short)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string name, logic [191:0] act,
                     logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops one expected word.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && valid_input === 1'b1) begin
      if (sb.size() == 0) begin
        chk("extra_strobe", 192'd1, 192'd0);
      end else begin
        logic [191:0] e;
        e = sb.pop_front();
        chk("din", din, e);
      end
    end
    if (rst_i === 1'b1 && done_o === 1'b1)
      chk("words_left_at_done", 192'(sb.size()), 192'd0);
  end

  // Reference: reduce each supplied value, zero the rest, cut into words.
  task automatic expect_run(int last_idx, output bit er,
                            output bit es);
    int n;
    int vals[256];
    logic [191:0] w;
    n  = (last_idx >= 0) ? last_idx + 1 : 256;
    er = 0;
    for (int i = 0; i < 256; i++) vals[i] = 0;
    for (int i = 0; i < n; i++) begin
      if (coef[i] >= QM) begin
        vals[i] = coef[i] - QM;
        er = 1;
      end else begin
        vals[i] = coef[i];
      end
    end
    es = (last_idx >= 0) && (last_idx < 255);
    for (int wi = 0; wi < 16; wi++) begin
      w = '0;
      for (int k = 0; k < 16; k++)
        w[12*k +: 12] = 12'(vals[16*wi + k]);
      sb.push_back(w);
    end
  endtask

  task automatic chk_zero(string name);
    chk({name, "_din"}, din, 192'd0);
    chk({name, "_ctl"},
        192'({start, valid_input, s_ready, busy,
              done_o, err_range, err_short, is_NTT}),
        192'd0);
  endtask

  // Entered at posedge+1; returns at posedge+1 in LOAD-bound state.
  task automatic issue_go(bit m);
    go_i   = 1'b1;
    mode_i = m;
    @(posedge clk_i); #1;
    go_i   = 1'b0;
    mode_i = 1'($urandom);
    @(negedge clk_i);
    chk("start_pulse", 192'(start), 192'd1);
    chk("busy_start", 192'(busy), 192'd1);
    @(posedge clk_i); #1;
    chk("start_one_cycle", 192'(start), 192'd0);
  endtask

  task automatic feed(int n_xfer, int pv, int inj, int last_idx,
                      bit m);
    int idx = 0;
    int cyc = 0;
    while (idx < n_xfer && cyc < 3000) begin
      s_valid = (pv >= 100) || ($urandom_range(0, 99) < pv);
      s_data  = s_valid ? 12'(coef[idx]) : 12'($urandom);
      s_last  = s_valid && (idx == last_idx);
      if (idx == inj) begin
        go_i     = 1'b1;
        done_all = 1'b1;
        mode_i   = ~m;
      end
      @(negedge clk_i);
      if (s_valid && s_ready) idx++;
      @(posedge clk_i); #1;
      go_i     = 1'b0;
      done_all = 1'b0;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (idx < n_xfer) chk("feed_timeout", 192'(idx), 192'(n_xfer));
  endtask

  task automatic do_run(bit m, int last_idx, int pv, int inj);
    bit er, es;
    int n, cyc;
    n = (last_idx >= 0) ? last_idx + 1 : 256;
    expect_run(last_idx, er, es);
    issue_go(m);
    feed(n, pv, inj, last_idx, m);
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("strobes_missing", 192'(sb.size()), 192'd0);
    @(negedge clk_i);
    chk("wait_state",
        192'({s_ready, busy, done_o}), 192'(3'b010));
    @(posedge clk_i); #1;
    done_all = 1'b1;
    @(posedge clk_i); #1;
    done_all = 1'b0;
    @(negedge clk_i);
    chk("done_pulse", 192'(done_o), 192'd1);
    chk("is_NTT", 192'(is_NTT), 192'(m));
    chk("err_range", 192'(err_range), 192'(er));
    chk("err_short", 192'(err_short), 192'(es));
    @(negedge clk_i);
    chk("done_one_cycle", 192'({done_o, busy}), 192'd0);
    chk("flags_persist",
        192'({is_NTT, err_range, err_short}),
        192'({m, er, es}));
    @(posedge clk_i); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; go_i = 1'b0; mode_i = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    done_all = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Sequential values, s_last on the 256th coefficient.
    for (int i = 0; i < 256; i++) coef[i] = i;
    do_run(1'b1, 255, 100, -1);

    // Reduction boundaries then random raw values.
    for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
    coef[0] = 3328; coef[1] = 3329; coef[2] = 4095;
    do_run(1'b0, -1, 100, -1);

    // Early s_last at index 19, then padding.
    for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 3328);
    do_run(1'b1, 19, 100, -1);

    // Early s_last inside the final word: no padding words.
    for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 3328);
    do_run(1'b0, 247, 100, -1);

    // Bursty valid at 50%.
    for (int i = 0; i < 256; i++) coef[i] = i;
    do_run(1'b1, -1, 50, -1);

    // Stray go_i / done_all mid-load.
    for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
    do_run(1'b1, -1, 70, 50);

    // Reset after 100 coefficients, then a fresh iNTT run.
    begin
      bit er, es;
      for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
      expect_run(-1, er, es);
      issue_go(1'b1);
      feed(100, 100, -1, -1, 1'b1);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk_zero("midrun_reset");
      sb.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk_zero("post_reset_idle");
      @(posedge clk_i); #1;
    end
    for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
    do_run(1'b0, -1, 100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_coef_packer.md
NTT_COEF_PACKER -- requirements
Module: ntt_coef_packer

Interface
REQ-001 SHALL take parameters: DATA_WIDTH 12 (coefficient bits); LANES 16 (coefficients per word); INPUT_WIDTH 192 (=DATA_WIDTH*LANES); N_WORDS 16 (words per polynomial, 256 coefficients); Q 3329 (modulus).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 rst_i  in  1  asynchronous active-low reset.
REQ-005 go_i  in  1  one-cycle request to run one transform.
REQ-006 mode_i  in  1  1=NTT, 0=iNTT; sampled with go_i.
REQ-007 s_valid  in  1  coefficient valid.
REQ-008 s_data  in  12  raw coefficient, 0..4095.
REQ-009 s_last  in  1  marks final coefficient supplied.
REQ-010 s_ready  out  1  packer accepts s_data this cycle.
REQ-011 done_all  in  1  completion pulse from the NTT core.
REQ-012 start  out  1  one-cycle start pulse to the NTT core.
REQ-013 is_NTT  out  1  latched mode, held stable from start until done_o.
REQ-014 valid_input  out  1  one-cycle strobe qualifying din.
REQ-015 din  out  192  packed word; lane k = din[12k+11:12k].
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done_o  out  1  one-cycle completion pulse.
REQ-018 err_range  out  1  sticky; some s_data >= Q in this run.
REQ-019 err_short  out  1  sticky; s_last arrived before coefficient 256.

Function
REQ-020 SHALL implement FSM IDLE -> START -> LOAD -> (PAD) -> WAIT -> DONE -> IDLE.
REQ-021 IDLE: go_i=1 -> START; latch mode_i into is_NTT; clear err_range and err_short.
REQ-022 START: start=1 for exactly one cycle, then LOAD.
REQ-023 LOAD: s_ready=1; a transfer occurs when s_valid&&s_ready.
REQ-024 Each transfer SHALL write the reduced coefficient into lane lane_cnt (4-bit) of the assembly register; lane 0 is the first coefficient.
REQ-025 Reduction: out = s_data>=Q ? s_data-Q : s_data (single subtraction; 4095 -> 766); s_data>=Q sets err_range.
REQ-026 On the transfer into lane 15, din SHALL load the completed word and valid_input SHALL be 1 on the next cycle; word_cnt increments; there is no stall (1 coefficient/cycle sustained).
REQ-027 lane_cnt and word_cnt wrap 15->0; a word completing with word_cnt=15 -> WAIT (s_ready=0 from the following cycle).
REQ-028 s_last on the 256th coefficient is normal; s_last absent on the 256th is ignored.
REQ-029 s_last on an earlier transfer: set err_short, zero the remaining lanes, emit that word, -> PAD.
REQ-030 PAD: s_ready=0; emit all-zero words, one valid_input per cycle, until 16 words total; -> WAIT.
REQ-031 WAIT: s_ready=0; on done_all=1 -> DONE. done_all in any other state is ignored.
REQ-032 DONE: done_o=1 for one cycle -> IDLE; errors and is_NTT persist until the next go_i.
REQ-033 go_i outside IDLE SHALL be ignored; s_valid outside LOAD SHALL be ignored (no transfer).
REQ-034 valid_input SHALL never be asserted on two words with identical word_cnt within one run; exactly 16 strobes per run.

Reset
REQ-035 rst_i=0 SHALL force IDLE immediately, at any time including mid-run; lane_cnt, word_cnt, din, start, valid_input, s_ready, busy, done_o, err_range, err_short, is_NTT all go to 0.
REQ-036 After rst_i deasserts, no output changes until go_i; a partial word in progress is discarded.

Verification
REQ-037 go_i, mode_i=1, then 256 back-to-back coefficients i=0..255 -> start pulse 1 cycle after go_i; 16 valid_input strobes, word w lane k = 16w+k; is_NTT=1; done_o one cycle after done_all.
REQ-038 Coefficient values 3328, 3329, 4095 -> lanes hold 3328, 0, 766; err_range=1.
REQ-039 s_last on coefficient 20 (index 19) -> word 1 lanes 4..15 = 0; words 2..15 all-zero on consecutive cycles; err_short=1; total strobes 16.
REQ-040 s_valid toggled randomly at 50% -> identical din sequence to REQ-037; no extra or missing strobes.
REQ-041 rst_i low after 100 coefficients, release, new run with mode_i=0 -> all outputs 0 during reset; new run packs from lane 0, word 0; is_NTT=0.
REQ-042 go_i and done_all pulsed during LOAD -> ignored; done_o only after done_all in WAIT.
